// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction prefetch stage.
// Owns the fetch PC, drives the asynchronous instruction memory address and
// captures each returned word with its PC into an in-order FIFO. Decode drains
// the FIFO with valid/ready. A redirect flushes the FIFO and restarts fetch.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_dout,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [31:0]                deq_inst,
  output logic [31:0]                deq_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [31:0]   PC_MASK  = 32'hFFFF_FFFC;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic [31:0]   mem_pc_q   [DEPTH];
  logic [31:0]   mem_inst_q [DEPTH];

  logic deq_s;
  logic enq_s;
  logic valid_s;

  assign valid_s = (count_q != CNT_ZERO);

  // Handshake qualification; a full FIFO still accepts when it dequeues.
  always_comb begin
    deq_s = valid_s & deq_ready;
    enq_s = fetch_en & ~redirect_valid & ((count_q < DEPTH_C) | deq_s);
  end

  // Next-state for fetch PC, pointers and occupancy; redirect wins.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      // Any same-cycle dequeue is discarded along with the rest.
      fetch_pc_d = redirect_pc & PC_MASK;
      rd_ptr_d   = wr_ptr_q;
      count_d    = CNT_ZERO;
    end else begin
      if (enq_s) begin
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        wr_ptr_d   = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC & PC_MASK;
      rd_ptr_q   <= PTR_ZERO;
      wr_ptr_q   <= PTR_ZERO;
      count_q    <= CNT_ZERO;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are never cleared because outputs are gated.
  always_ff @(posedge clk) begin
    if (enq_s && !reset) begin
      mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
      mem_inst_q[wr_ptr_q] <= imem_dout;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign deq_valid = valid_s;
  assign deq_inst  = valid_s ? mem_inst_q[rd_ptr_q] : 32'h0;
  assign deq_pc    = valid_s ? mem_pc_q[rd_ptr_q]   : 32'h0;
  assign count     = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: directed scenarios followed by random
// traffic, checked against a queue-based reference model via a scoreboard.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic [$clog2(DEPTH):0] count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        sb[$];          // expected FIFO contents, head first
  logic [31:0] model_pc;       // expected fetch PC
  logic        chk_en;
  int          n_cmp;
  int          n_err;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_dout(imem_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_inst(deq_inst), .deq_pc(deq_pc), .count(count)
  );

  // Instruction memory: word k holds 0x1000 + k.
  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    return 32'h1000 + (addr >> 2);
  endfunction

  assign imem_dout = imem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, compare DUT outputs with the scoreboard head and pop
  // on every handshake the model expects.
  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_addr", imem_addr, model_pc);
      check("count", 32'(count), 32'(sb.size()));
      if (sb.size() == 0) begin
        check("deq_valid_empty", {31'b0, deq_valid}, 32'd0);
        check("deq_pc_empty", deq_pc, 32'd0);
        check("deq_inst_empty", deq_inst, 32'd0);
      end else begin
        check("deq_valid", {31'b0, deq_valid}, 32'd1);
        check("deq_pc", deq_pc, sb[0].pc);
        check("deq_inst", deq_inst, sb[0].inst);
        if (deq_ready) void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus; after the monitor has run, advance the model for
  // the upcoming edge.
  task automatic cyc(input logic fe, input logic rdy, input logic rv,
                     input logic [31:0] rpc, input logic rst);
    @(posedge clk);
    #1;
    fetch_en       = fe;
    deq_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    reset          = rst;
    #6;
    if (rst) begin
      sb.delete();
      model_pc = RESET_PC & 32'hFFFF_FFFC;
    end else if (rv) begin
      sb.delete();
      model_pc = rpc & 32'hFFFF_FFFC;
    end else if (fe && sb.size() < DEPTH) begin
      sb.push_back({model_pc, imem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    chk_en         = 1'b0;
    reset          = 1'b1;
    fetch_en       = 1'b1;
    deq_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_pc       = RESET_PC & 32'hFFFF_FFFC;
    #6 chk_en = 1'b1;

    // Reset, then straight-line streaming with decode always ready.
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // Backpressure until full, one combined deq/enq, then drain.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // Build occupancy to 3, then redirect to an unaligned 0x203.
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h203, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // Fetch stall mid-stream: drain to empty and resume without gap.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // PC wrap across 2^32.
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // Fill, then reset together with redirect.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'h300, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 7) != 0),
          ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 15) == 0),
          $urandom,
          ($urandom_range(0, 63) == 0));
    end
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #6;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction prefetch stage that sits directly downstream of the instruction memory. It owns the fetch PC and drives the memory's asynchronous read address. Each returned instruction word is captured, together with its PC, into a small in-order FIFO. The decode stage drains the FIFO with a valid/ready handshake, and a redirect from execute (branch/jump) flushes the FIFO and restarts fetch at a new PC.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0: fetch PC loaded on reset.

- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- fetch_en  input  1  when 0, no new enqueue (fetch PC holds); dequeue still allowed.
- imem_addr  output  32  byte address to instruction memory; equals fetch_pc.
- imem_dout  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  flush FIFO and restart fetch this cycle.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored (forced to 0).
- deq_valid  output  1  FIFO non-empty.
- deq_ready  input  1  decode accepts the head entry this cycle.
- deq_inst  output  32  head instruction; 0 when deq_valid=0.
- deq_pc  output  32  head PC; 0 when deq_valid=0.
- count  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- State: fetch_pc[31:0], circular buffer of DEPTH x {pc, inst}, rd_ptr, wr_ptr, count.
- deq = deq_valid & deq_ready.
- enq = fetch_en & ~redirect_valid & (count < DEPTH | deq). A full FIFO accepts an enqueue in the same cycle as a dequeue.
- On enq: write {fetch_pc, imem_dout} at wr_ptr, advance wr_ptr, and set fetch_pc <= fetch_pc + 4 (mod 2^32; 32'hFFFFFFFC wraps to 0).
- On deq: advance rd_ptr. Pointers wrap at DEPTH.
- count next = count + enq - deq. Simultaneous enq and deq leave count unchanged.
- Redirect has priority over everything:
  - count <= 0 and rd_ptr <= wr_ptr.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No enqueue that cycle.
  - A deq handshake in the same cycle is considered consumed by decode, but the entry is discarded with the rest.
- Reset: fetch_pc <= {RESET_PC[31:2], 2'b00}, count <= 0, pointers <= 0. Reset overrides redirect and fetch_en. Reset mid-operation discards all entries.
- FIFO storage contents need not be cleared; outputs are gated by deq_valid.

## Timing
- Reset values: imem_addr = RESET_PC, deq_valid = 0, deq_inst = 0, deq_pc = 0, count = 0.
- imem_addr is a pure register output; no combinational path from any input.
- deq_valid, deq_inst, deq_pc and count are derived only from registered state. There is no combinational path from deq_ready or redirect_valid to them.
- Fetch-to-decode latency: an instruction sampled at edge N is visible at deq_* from cycle N+1.
- First cycle after reset release: enq occurs at that edge, and deq_valid=1 the following cycle.
- Redirect at edge N: deq_valid=0 in cycle N+1, imem_addr = redirect_pc in cycle N+1, and the first redirected instruction is visible in cycle N+2.
- Sustained throughput: one instruction/cycle with deq_ready held high.
- Full with deq_ready=0: enqueue stops, and fetch_pc and imem_addr hold.

## Test plan
- Straight line: reset with RESET_PC=0, imem holds word k = 0x1000+k, and deq_ready=1 throughout. Required: deq_pc = 0, 4, 8, … on consecutive cycles from cycle 2 after reset, with deq_inst = 0x1000, 0x1001, …, and count stays 1.
- Backpressure/full: deq_ready=0 for 8 cycles. Required: count saturates at 4 and imem_addr holds at 0x10. Then raise deq_ready for one cycle with the FIFO full: the dequeue and enqueue happen together, count stays 4, and imem_addr goes to 0x14.
- Redirect: a redirect of 0x200 while count=3 and deq_ready=1. Required: next cycle count=0, deq_valid=0, imem_addr=0x200; the cycle after, deq_pc=0x200. A redirect_pc of 0x203 yields 0x200.
- fetch_en=0 for 3 cycles mid-stream: the FIFO drains to empty, imem_addr holds its value, and fetch resumes from the same PC with no gap or duplicate.
- Wrap: redirect to 0xFFFFFFF8 with deq_ready=1. Required: deq_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Reset mid-operation: assert reset with count=4 and reset asserted together with redirect_valid. Required: next cycle count=0, deq_valid=0, imem_addr=RESET_PC.
